// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage core's inter-stage registers: bundle widths,
// control-bit positions and the NOP control value.
package pipe_pkg;

  localparam int unsigned IF_ID_DATA_W  = 64;
  localparam int unsigned IF_ID_CTRL_W  = 1;
  localparam int unsigned ID_EX_DATA_W  = 96;
  localparam int unsigned ID_EX_CTRL_W  = 8;
  localparam int unsigned EX_MEM_DATA_W = 69;
  localparam int unsigned EX_MEM_CTRL_W = 4;
  localparam int unsigned MEM_WB_DATA_W = 37;
  localparam int unsigned MEM_WB_CTRL_W = 2;

  // Bit positions inside the ID/EX control bundle
  localparam int unsigned CTRL_MEM_WEN      = 0;
  localparam int unsigned CTRL_WB_SEL       = 1;
  localparam int unsigned CTRL_ALU_SRC      = 2;
  localparam int unsigned CTRL_RD_EN        = 3;
  localparam int unsigned CTRL_ALU_CTRL_LSB = 4;
  localparam int unsigned CTRL_ALU_CTRL_MSB = 7;

  localparam logic [ID_EX_CTRL_W-1:0] CTRL_NOP = '0;

  // True when a control word can change architectural state
  function automatic logic ctrl_has_side_effect(input logic [ID_EX_CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEM_WEN] | ctrl[CTRL_RD_EN];
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One valid+data+ctrl holding register. clear beats load beats unload; ctrl is zeroed
// whenever the entry becomes empty so an empty slot always reads as a NOP.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = ID_EX_DATA_W,
  parameter int unsigned CTRL_W = ID_EX_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              unload,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [CTRL_W-1:0] ld_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= ld_data;
      ctrl_q  <= ld_ctrl;
    end else if (unload) begin
      // data is left stale on purpose; only ctrl must read as a NOP
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush, NOP bubbles,
// optional skid entry (registered in_ready) and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = ID_EX_DATA_W,
  parameter int unsigned CTRL_W  = ID_EX_CTRL_W,
  parameter int unsigned SKID_EN = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic              in_fire;
  logic              out_fire;
  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  stall_d;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

  if (SKID_EN != 0) begin : g_skid
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              main_take;
    logic              main_load;
    logic              skid_load;
    logic              skid_drain;
    logic [DATA_W-1:0] main_src_data;
    logic [CTRL_W-1:0] main_src_ctrl;

    // in_ready depends only on state, which breaks the out_ready -> in_ready path
    assign in_ready = ~skid_valid;

    always_comb begin
      main_take     = ~main_valid | out_fire;
      main_load     = main_take & (skid_valid | in_fire);
      skid_drain    = skid_valid & main_take;
      skid_load     = in_fire & ((main_valid & ~out_fire) | skid_drain);
      // the skid entry is older than anything on the input, so it goes first
      main_src_data = skid_valid ? skid_data : in_data;
      main_src_ctrl = skid_valid ? skid_ctrl : in_ctrl;
    end

    pipe_entry_reg #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_main (
      .clk     (clk),
      .reset   (reset),
      .clear   (flush),
      .load    (main_load),
      .unload  (out_fire),
      .ld_data (main_src_data),
      .ld_ctrl (main_src_ctrl),
      .valid   (main_valid),
      .data    (main_data),
      .ctrl    (main_ctrl)
    );

    pipe_entry_reg #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_skid (
      .clk     (clk),
      .reset   (reset),
      .clear   (flush),
      .load    (skid_load),
      .unload  (skid_drain),
      .ld_data (in_data),
      .ld_ctrl (in_ctrl),
      .valid   (skid_valid),
      .data    (skid_data),
      .ctrl    (skid_ctrl)
    );
  end else begin : g_single
    assign in_ready = ~main_valid | out_ready;

    pipe_entry_reg #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_main (
      .clk     (clk),
      .reset   (reset),
      .clear   (flush),
      .load    (in_fire),
      .unload  (out_fire),
      .ld_data (in_data),
      .ld_ctrl (in_ctrl),
      .valid   (main_valid),
      .data    (main_data),
      .ctrl    (main_ctrl)
    );
  end

  // Counts back-pressure cycles for performance monitoring; flush does not clear it
  always_comb begin
    stall_d = stall_q;
    if (main_valid && !out_ready && stall_q != CntMax) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance and a single-entry instance with a 4-bit
// stall counter, each checked by a scoreboard queue popped by an independent monitor.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  typedef logic [DW+CW-1:0] ent_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [15:0]   a_stall;

  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [3:0]    b_stall;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t qa[$];
  ent_t qb[$];

  pipe_stage_reg #(
    .DATA_W  (DW),
    .CTRL_W  (CW),
    .SKID_EN (1),
    .CNT_W   (16)
  ) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .flush     (a_flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .in_ctrl   (a_in_ctrl),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_ctrl  (a_out_ctrl),
    .stall_cnt (a_stall)
  );

  pipe_stage_reg #(
    .DATA_W  (DW),
    .CTRL_W  (CW),
    .SKID_EN (0),
    .CNT_W   (4)
  ) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .flush     (b_flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_ctrl   (b_in_ctrl),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_ctrl  (b_out_ctrl),
    .stall_cnt (b_stall)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [DW-1:0] d, input logic [CW-1:0] c, input bit deliver);
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_ctrl  = c;
    if (deliver) qa.push_back({c, d});
  endtask

  task automatic b_send(input logic [DW-1:0] d, input logic [CW-1:0] c, input bit deliver);
    b_in_valid = 1'b1;
    b_in_data  = d;
    b_in_ctrl  = c;
    if (deliver) qb.push_back({c, d});
  endtask

  // Monitors: an out_fire seen at the falling edge completes on the next rising edge
  always @(negedge clk) begin
    if (reset && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_unexpected_out: got data %0h ctrl %0h, expected no entry",
                 a_out_data, a_out_ctrl);
      end else begin
        ent_t e;
        e = qa.pop_front();
        check("a_out_data", 64'(a_out_data), 64'(e[DW-1:0]));
        check("a_out_ctrl", 64'(a_out_ctrl), 64'(e[DW+CW-1:DW]));
      end
    end
    if (!a_out_valid) check("a_bubble_ctrl", 64'(a_out_ctrl), 64'd0);
  end

  always @(negedge clk) begin
    if (reset && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_unexpected_out: got data %0h ctrl %0h, expected no entry",
                 b_out_data, b_out_ctrl);
      end else begin
        ent_t e;
        e = qb.pop_front();
        check("b_out_data", 64'(b_out_data), 64'(e[DW-1:0]));
        check("b_out_ctrl", 64'(b_out_ctrl), 64'(e[DW+CW-1:DW]));
      end
    end
    if (!b_out_valid) check("b_bubble_ctrl", 64'(b_out_ctrl), 64'd0);
  end

  initial begin
    reset       = 1'b0;
    a_flush     = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 32'h1234;
    a_in_ctrl   = 8'h11;
    a_out_ready = 1'b0;
    b_flush     = 1'b0;
    b_in_valid  = 1'b0;
    b_in_data   = '0;
    b_in_ctrl   = '0;
    b_out_ready = 1'b0;

    // Reset held with input offered: nothing captured
    step();
    step();
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_out_ctrl", 64'(a_out_ctrl), 64'd0);
    check("rst_stall_cnt", 64'(a_stall), 64'd0);
    check("rst_in_ready", 64'(a_in_ready), 64'd1);

    reset = 1'b1;
    a_send(32'h1234, 8'h11, 1'b1);
    a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    check("first_out_valid", 64'(a_out_valid), 64'd1);
    check("first_out_data", 64'(a_out_data), 64'h1234);
    step();

    // Back-to-back streaming
    for (int i = 1; i <= 4; i++) begin
      a_send(DW'(i), CW'(8'h20 + i), 1'b1);
      step();
      check("stream_out_valid", 64'(a_out_valid), 64'd1);
      check("stream_out_data", 64'(a_out_data), 64'(i));
      check("stream_in_ready", 64'(a_in_ready), 64'd1);
    end
    a_in_valid = 1'b0;
    step();
    check("stream_drained", 64'(a_out_valid), 64'd0);

    // Stall fills the skid, then drains in order
    a_out_ready = 1'b0;
    a_send(32'hA0A0, 8'h3A, 1'b1);
    step();
    check("stall_in_ready_a", 64'(a_in_ready), 64'd1);
    check("stall_cnt_0", 64'(a_stall), 64'd0);
    a_send(32'hB0B0, 8'h3B, 1'b1);
    step();
    a_in_valid = 1'b0;
    check("stall_in_ready_b", 64'(a_in_ready), 64'd0);
    check("stall_cnt_1", 64'(a_stall), 64'd1);
    check("stall_head", 64'(a_out_data), 64'hA0A0);
    step();
    check("stall_cnt_2", 64'(a_stall), 64'd2);
    check("stall_in_ready_held", 64'(a_in_ready), 64'd0);
    a_out_ready = 1'b1;
    step();
    check("drain_out_data", 64'(a_out_data), 64'hB0B0);
    check("drain_out_valid", 64'(a_out_valid), 64'd1);
    check("drain_in_ready", 64'(a_in_ready), 64'd1);
    check("drain_stall_cnt", 64'(a_stall), 64'd2);
    step();
    check("drain_empty", 64'(a_out_valid), 64'd0);

    // Flush with main and skid full while C is offered
    a_out_ready = 1'b0;
    a_send(32'hA1, 8'h5A, 1'b0);
    step();
    a_send(32'hB1, 8'h5B, 1'b0);
    step();
    check("flush1_skid_full", 64'(a_in_ready), 64'd0);
    check("flush1_stall_pre", 64'(a_stall), 64'd3);
    a_send(32'hC1, 8'h5C, 1'b0);
    a_flush = 1'b1;
    step();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    check("flush1_out_valid", 64'(a_out_valid), 64'd0);
    check("flush1_out_ctrl", 64'(a_out_ctrl), 64'd0);
    check("flush1_in_ready", 64'(a_in_ready), 64'd1);
    check("flush1_stall_kept", 64'(a_stall), 64'd4);

    // Flush with a real in_fire on the same edge
    a_send(32'hA2, 8'h6A, 1'b0);
    step();
    check("flush2_in_ready", 64'(a_in_ready), 64'd1);
    a_send(32'hC2, 8'h6C, 1'b0);
    a_flush = 1'b1;
    step();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    check("flush2_out_valid", 64'(a_out_valid), 64'd0);
    check("flush2_in_ready_after", 64'(a_in_ready), 64'd1);
    check("flush2_stall", 64'(a_stall), 64'd5);
    step();
    check("flush2_no_leak", 64'(a_out_valid), 64'd0);

    // Bubble after an all-ones control word
    a_out_ready = 1'b1;
    a_send(32'hBEEF, 8'hFF, 1'b1);
    step();
    a_in_valid = 1'b0;
    check("bubble_ctrl_live", 64'(a_out_ctrl), 64'hFF);
    step();
    check("bubble_out_valid", 64'(a_out_valid), 64'd0);
    check("bubble_out_ctrl", 64'(a_out_ctrl), 64'd0);
    check("bubble_data_held", 64'(a_out_data), 64'hBEEF);

    // Single-entry instance: combinational in_ready and counter saturation
    b_send(32'h55, 8'h0F, 1'b1);
    check("b_in_ready_empty", 64'(b_in_ready), 64'd1);
    step();
    b_in_valid = 1'b0;
    check("b_out_valid", 64'(b_out_valid), 64'd1);
    check("b_in_ready_full", 64'(b_in_ready), 64'd0);
    b_out_ready = 1'b1;
    #1;
    check("b_in_ready_follow_hi", 64'(b_in_ready), 64'd1);
    b_out_ready = 1'b0;
    #1;
    check("b_in_ready_follow_lo", 64'(b_in_ready), 64'd0);
    for (int i = 0; i < 14; i++) step();
    check("b_stall_14", 64'(b_stall), 64'd14);
    step();
    check("b_stall_15", 64'(b_stall), 64'd15);
    for (int i = 0; i < 5; i++) step();
    check("b_stall_sat", 64'(b_stall), 64'd15);
    b_out_ready = 1'b1;
    step();
    check("b_drained", 64'(b_out_valid), 64'd0);
    check("b_stall_final", 64'(b_stall), 64'd15);

    // Asynchronous reset in the middle of a stall
    a_out_ready = 1'b0;
    a_send(32'h77, 8'h77, 1'b0);
    step();
    a_in_valid = 1'b0;
    step();
    step();
    check("mid_out_valid", 64'(a_out_valid), 64'd1);
    check("mid_stall", 64'(a_stall), 64'd7);
    #2;
    reset = 1'b0;
    #1;
    check("async_out_valid", 64'(a_out_valid), 64'd0);
    check("async_out_ctrl", 64'(a_out_ctrl), 64'd0);
    check("async_stall", 64'(a_stall), 64'd0);
    check("async_in_ready", 64'(a_in_ready), 64'd1);
    check("async_b_stall", 64'(b_stall), 64'd0);
    step();
    reset = 1'b1;
    step();
    check("post_reset_empty", 64'(a_out_valid), 64'd0);

    check("a_queue_empty", 64'(qa.size()), 64'd0);
    check("b_queue_empty", 64'(qb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
